// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS-I integer pipeline.
//
// Contents:
//   - primary opcode, SPECIAL funct and REGIMM rt-field encodings
//   - bit positions inside the alu_exception vector
//   - alu_op_e: internal ALU operation selector used by the execute stage
//   - sext16 / forward_operand helpers shared by the execute stage
package mips_pkg;

  // Primary opcodes, inst[31:26]
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes, inst[5:0]
  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SLLV    = 6'h04;
  localparam logic [5:0] F_SRLV    = 6'h06;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_JALR    = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_BREAK   = 6'h0D;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_XOR     = 6'h26;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2A;
  localparam logic [5:0] F_SLTU    = 6'h2B;

  // REGIMM branch selectors live in the rt field, inst[20:16]
  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  // alu_exception bit positions
  localparam int EXC_W    = 3;
  localparam int EXC_OVF  = 0;
  localparam int EXC_ADDR = 1;
  localparam int EXC_INST = 2;

  typedef enum logic [3:0] {
    ALU_NONE,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI,
    ALU_LINK
  } alu_op_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Picks the newest value of a source register. r0 is hard-wired to zero,
  // the MEM-stage result beats the writeback value, and the register file
  // is the fallback. mem_ok already folds in "writes, not a load, not killed".
  function automatic logic [31:0] forward_operand(
    input logic [4:0]  src,
    input logic [31:0] rf_val,
    input logic        mem_ok,
    input logic [4:0]  mem_idx,
    input logic [31:0] mem_val,
    input logic        wb_en,
    input logic [4:0]  wb_idx,
    input logic [31:0] wb_val
  );
    logic [31:0] v;
    if (src == 5'd0)                   v = 32'd0;
    else if (mem_ok && mem_idx == src) v = mem_val;
    else if (wb_en && wb_idx == src)   v = wb_val;
    else                               v = rf_val;
    return v;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// pipe_delay: synchronous-reset shift register of DEPTH stages.
//
// Parameters:
//   WIDTH     - bits per stage
//   DEPTH     - number of register stages (>= 1); dout is din delayed DEPTH cycles
//   RESET_VAL - value every stage takes while rst is high
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   din  - value entering the first stage
//   dout - value leaving the last stage
module pipe_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/alu_bypass_stage.sv
// alu_bypass_stage: execute stage of the 5-stage MIPS-I integer pipeline.
//
// Forwards newer results from MEM (this stage's own registered outputs) and
// writeback, performs the ALU operation, resolves register-based branches
// and jumps, flags exceptions, and registers everything for the MEM stage.
// Latency is one cycle; a new instruction is accepted every cycle.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   inst, pc            - instruction in execute and its address
//   rs_rf, rt_rf        - register-file values of inst[25:21] / inst[20:16]
//   dest_sel_rt/ra      - destination select (ra = r31 wins over rt)
//   imm_sext, imm_shamt - how the constant operand is built
//   const_to_rs/rt      - replace operand A / B with the constant
//   squash              - instruction is on the wrong path
//   mem_we, mem_is_load - what the MEM-stage instruction does
//   wb_we/index/value   - register write happening this cycle
//   rd_index, rd_value  - registered destination and result / address
//   br_late_enable/target - registered fetch redirect
//   memop_disable       - registered kill of mem access and register write
//   alu_exception       - registered exception flags
module alu_bypass_stage #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs_rf,
  input  logic [31:0] rt_rf,
  input  logic        dest_sel_rt,
  input  logic        dest_sel_ra,
  input  logic        imm_sext,
  input  logic        imm_shamt,
  input  logic        const_to_rs,
  input  logic        const_to_rt,
  input  logic        squash,
  input  logic        mem_we,
  input  logic        mem_is_load,
  input  logic        wb_we,
  input  logic [4:0]  wb_index,
  input  logic [31:0] wb_value,
  output logic [4:0]  rd_index,
  output logic [31:0] rd_value,
  output logic        br_late_enable,
  output logic [31:0] br_late_target,
  output logic        memop_disable,
  output logic [2:0]  alu_exception
);

  import mips_pkg::*;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [31:0] imm_sx;
  logic [31:0] const_val;
  logic        mem_fwd_ok;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_a;
  logic [31:0] op_b;

  alu_op_e     alu_op;
  logic        shift_var;
  logic        ovf_chk;
  logic        is_mem;
  logic        br_cond;
  logic        br_reg;
  logic        exc_inst;

  logic [31:0] add_b;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  shamt;
  logic [31:0] alu_result;
  logic        ovf;
  logic [EXC_W-1:0] exc_raw;

  logic [4:0]  rd_index_d;
  logic [31:0] rd_value_d;
  logic        br_en_d;
  logic [31:0] br_target_d;
  logic        memop_disable_d;
  logic [2:0]  alu_exception_d;

  logic [36:0] data_q;
  logic [4:0]  ctrl_q;
  logic [31:0] target_q;

  assign opcode = inst[31:26];
  assign funct  = inst[5:0];
  assign rs_idx = inst[25:21];
  assign rt_idx = inst[20:16];
  assign imm_sx = sext16(inst[15:0]);

  // The shift-amount form wins over sign/zero extension of the immediate.
  always_comb begin
    if (imm_shamt)     const_val = {27'b0, inst[10:6]};
    else if (imm_sext) const_val = imm_sx;
    else               const_val = {16'b0, inst[15:0]};
  end

  // The MEM-stage instruction is our own registered output. A load has no
  // value yet (covered by the load delay slot) and a killed instruction
  // never writes, so neither may be forwarded.
  assign mem_fwd_ok = mem_we && !mem_is_load && !memop_disable;

  always_comb begin
    fwd_a = forward_operand(rs_idx, rs_rf, mem_fwd_ok, rd_index, rd_value,
                            wb_we, wb_index, wb_value);
    fwd_b = forward_operand(rt_idx, rt_rf, mem_fwd_ok, rd_index, rd_value,
                            wb_we, wb_index, wb_value);
    op_a  = const_to_rs ? const_val : fwd_a;
    op_b  = const_to_rt ? const_val : fwd_b;
  end

  // Decode opcode/funct into an ALU operation, side flags and the branch
  // condition. Unknown SPECIAL functs raise the instruction exception;
  // unknown primary opcodes simply produce nothing.
  always_comb begin
    alu_op    = ALU_NONE;
    shift_var = 1'b0;
    ovf_chk   = 1'b0;
    is_mem    = 1'b0;
    br_cond   = 1'b0;
    br_reg    = 1'b0;
    exc_inst  = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_SLL:     alu_op = ALU_SLL;
          F_SRL:     alu_op = ALU_SRL;
          F_SRA:     alu_op = ALU_SRA;
          F_SLLV:    begin alu_op = ALU_SLL; shift_var = 1'b1; end
          F_SRLV:    begin alu_op = ALU_SRL; shift_var = 1'b1; end
          F_SRAV:    begin alu_op = ALU_SRA; shift_var = 1'b1; end
          F_JR:      br_reg = 1'b1;
          F_JALR:    begin alu_op = ALU_LINK; br_reg = 1'b1; end
          F_SYSCALL: exc_inst = 1'b1;
          F_BREAK:   exc_inst = 1'b1;
          F_ADD:     begin alu_op = ALU_ADD; ovf_chk = 1'b1; end
          F_ADDU:    alu_op = ALU_ADD;
          F_SUB:     begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
          F_SUBU:    alu_op = ALU_SUB;
          F_AND:     alu_op = ALU_AND;
          F_OR:      alu_op = ALU_OR;
          F_XOR:     alu_op = ALU_XOR;
          F_NOR:     alu_op = ALU_NOR;
          F_SLT:     alu_op = ALU_SLT;
          F_SLTU:    alu_op = ALU_SLTU;
          default:   exc_inst = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt_idx)
          RT_BLTZ: br_cond = op_a[31];
          RT_BGEZ: br_cond = !op_a[31];
          default: br_cond = 1'b0;
        endcase
      end
      OP_JAL:   alu_op = ALU_LINK;
      OP_BEQ:   br_cond = (op_a == op_b);
      OP_BNE:   br_cond = (op_a != op_b);
      OP_BLEZ:  br_cond = op_a[31] || (op_a == 32'd0);
      OP_BGTZ:  br_cond = !op_a[31] && (op_a != 32'd0);
      OP_ADDI:  begin alu_op = ALU_ADD; ovf_chk = 1'b1; end
      OP_ADDIU: alu_op = ALU_ADD;
      OP_SLTI:  alu_op = ALU_SLT;
      OP_SLTIU: alu_op = ALU_SLTU;
      OP_ANDI:  alu_op = ALU_AND;
      OP_ORI:   alu_op = ALU_OR;
      OP_XORI:  alu_op = ALU_XOR;
      OP_LUI:   alu_op = ALU_LUI;
      OP_LW:    begin alu_op = ALU_ADD; is_mem = 1'b1; end
      OP_SW:    begin alu_op = ALU_ADD; is_mem = 1'b1; end
      default:  alu_op = ALU_NONE;
    endcase
  end

  // Loads and stores always add the sign-extended offset, independent of
  // how the decoder routed the constant.
  assign add_b = is_mem ? imm_sx : op_b;
  assign sum   = op_a + add_b;
  assign diff  = op_a - op_b;
  assign shamt = shift_var ? op_a[4:0] : inst[10:6];

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_result = sum;
      ALU_SUB:  alu_result = diff;
      ALU_AND:  alu_result = op_a & op_b;
      ALU_OR:   alu_result = op_a | op_b;
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_NOR:  alu_result = ~(op_a | op_b);
      ALU_SLT:  alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_result = {31'b0, op_a < op_b};
      ALU_SLL:  alu_result = op_b << shamt;
      ALU_SRL:  alu_result = op_b >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(op_b) >>> shamt);
      ALU_LUI:  alu_result = {inst[15:0], 16'b0};
      ALU_LINK: alu_result = pc + 32'd8;
      default:  alu_result = 32'd0;
    endcase
  end

  // Signed overflow: operands of equal sign (add) or opposite sign (sub)
  // producing a result whose sign differs from operand A.
  always_comb begin
    ovf = 1'b0;
    if (ovf_chk) begin
      if (alu_op == ALU_SUB) ovf = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
      else                   ovf = (op_a[31] == add_b[31]) && (sum[31] != op_a[31]);
    end
    exc_raw           = '0;
    exc_raw[EXC_OVF]  = ovf;
    exc_raw[EXC_ADDR] = is_mem && (sum[1:0] != 2'b00);
    exc_raw[EXC_INST] = exc_inst;
  end

  // Next-state values for the MEM-stage registers. A squashed instruction
  // still carries its index/value but can neither redirect fetch, raise an
  // exception nor reach memory/register file.
  always_comb begin
    if (dest_sel_ra)      rd_index_d = 5'd31;
    else if (dest_sel_rt) rd_index_d = rt_idx;
    else                  rd_index_d = inst[15:11];
    rd_value_d      = alu_result;
    br_en_d         = !squash && (br_cond || br_reg);
    br_target_d     = br_reg ? op_a : (pc + 32'd4 + (imm_sx << 2));
    alu_exception_d = squash ? 3'b000 : exc_raw;
    memop_disable_d = squash || (|exc_raw);
  end

  pipe_delay #(.WIDTH(37), .DEPTH(1), .RESET_VAL(37'd0)) u_data_reg (
    .clk  (clk),
    .rst  (rst),
    .din  ({rd_index_d, rd_value_d}),
    .dout (data_q)
  );

  pipe_delay #(.WIDTH(5), .DEPTH(1), .RESET_VAL(5'd0)) u_ctrl_reg (
    .clk  (clk),
    .rst  (rst),
    .din  ({br_en_d, memop_disable_d, alu_exception_d}),
    .dout (ctrl_q)
  );

  pipe_delay #(.WIDTH(32), .DEPTH(1), .RESET_VAL(RESET_PC)) u_target_reg (
    .clk  (clk),
    .rst  (rst),
    .din  (br_target_d),
    .dout (target_q)
  );

  assign rd_index       = data_q[36:32];
  assign rd_value       = data_q[31:0];
  assign br_late_enable = ctrl_q[4];
  assign memop_disable  = ctrl_q[3];
  assign alu_exception  = ctrl_q[2:0];
  assign br_late_target = target_q;

endmodule

// File: tb/tb_alu_bypass_stage.sv
// tb_alu_bypass_stage: scoreboard bench for the execute stage. Each test task
// drives one instruction per cycle, pushes the expected MEM-stage registers,
// and pops/compares them once the stage has registered the result.
module tb_alu_bypass_stage;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic [31:0] inst, pc, rs_rf, rt_rf;
  logic        dest_sel_rt, dest_sel_ra, imm_sext, imm_shamt;
  logic        const_to_rs, const_to_rt, squash;
  logic        mem_we, mem_is_load, wb_we;
  logic [4:0]  wb_index;
  logic [31:0] wb_value;
  logic [4:0]  rd_index;
  logic [31:0] rd_value;
  logic        br_late_enable;
  logic [31:0] br_late_target;
  logic        memop_disable;
  logic [2:0]  alu_exception;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] val;
    logic [31:0] vmask;
    logic        br;
    logic [31:0] tgt;
    logic        chk_tgt;
    logic        md;
    logic [2:0]  exc;
  } exp_t;

  exp_t  sb[$];
  string nm_q[$];
  int    compared   = 0;
  int    mismatched = 0;

  alu_bypass_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst           (inst),
    .pc             (pc),
    .rs_rf          (rs_rf),
    .rt_rf          (rt_rf),
    .dest_sel_rt    (dest_sel_rt),
    .dest_sel_ra    (dest_sel_ra),
    .imm_sext       (imm_sext),
    .imm_shamt      (imm_shamt),
    .const_to_rs    (const_to_rs),
    .const_to_rt    (const_to_rt),
    .squash         (squash),
    .mem_we         (mem_we),
    .mem_is_load    (mem_is_load),
    .wb_we          (wb_we),
    .wb_index       (wb_index),
    .wb_value       (wb_value),
    .rd_index       (rd_index),
    .rd_value       (rd_value),
    .br_late_enable (br_late_enable),
    .br_late_target (br_late_target),
    .memop_disable  (memop_disable),
    .alu_exception  (alu_exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
    return {OP_SPECIAL, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input logic [4:0] idx, input logic [31:0] val,
                              input logic vchk, input logic br, input logic [31:0] tgt,
                              input logic tchk, input logic md, input logic [2:0] exc);
    exp_t e;
    e.idx     = idx;
    e.val     = val;
    e.vmask   = vchk ? 32'hFFFF_FFFF : 32'h0;
    e.br      = br;
    e.tgt     = tgt;
    e.chk_tgt = tchk;
    e.md      = md;
    e.exc     = exc;
    return e;
  endfunction

  task automatic clear_inputs();
    rst = 1'b0; inst = 32'd0; pc = 32'd0; rs_rf = 32'd0; rt_rf = 32'd0;
    dest_sel_rt = 1'b0; dest_sel_ra = 1'b0; imm_sext = 1'b0; imm_shamt = 1'b0;
    const_to_rs = 1'b0; const_to_rt = 1'b0; squash = 1'b0;
    mem_we = 1'b0; mem_is_load = 1'b0; wb_we = 1'b0; wb_index = 5'd0; wb_value = 32'd0;
  endtask

  // Inputs are already set; record the expectation and let one edge pass.
  task automatic issue(input string nm, input exp_t e);
    sb.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x; string nm;
    for (int i = 0; i < 2; i++) begin
      clear_inputs();
      rst = 1'b1;
      inst = r_type(5'd1, 5'd2, 5'd3, 5'd0, F_ADDU); rs_rf = 32'd5; rt_rf = 32'd7;
      issue($sformatf("reset_%0d", i), mk(5'd0, 32'd0, 1, 0, RST_PC, 1, 0, 3'b000));
      x = sb.pop_front(); nm = nm_q.pop_front();
      compared++;
      if ({rd_index, rd_value & x.vmask, br_late_enable, memop_disable, alu_exception} !==
          {x.idx, x.val & x.vmask, x.br, x.md, x.exc}) begin
        mismatched++;
        $display("[TB] FAIL %s: got idx=%0d val=%h br=%b md=%b exc=%b, want idx=%0d val=%h br=%b md=%b exc=%b",
                 nm, rd_index, rd_value, br_late_enable, memop_disable, alu_exception,
                 x.idx, x.val, x.br, x.md, x.exc);
      end
      if (x.chk_tgt) begin
        compared++;
        if (br_late_target !== x.tgt) begin
          mismatched++;
          $display("[TB] FAIL %s target: got %h, want %h", nm, br_late_target, x.tgt);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t x; string nm;
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      case (i)
        0, 2: begin
          inst = r_type(5'd1, 5'd2, 5'd3, 5'd0, F_ADDU); rs_rf = 32'd5; rt_rf = 32'd7;
          issue("addu_r3", mk(5'd3, 32'd12, 1, 0, 0, 0, 0, 3'b000));
        end
        1: begin
          inst = r_type(5'd3, 5'd3, 5'd4, 5'd0, F_ADDU); mem_we = 1'b1;
          issue("fwd_mem", mk(5'd4, 32'd24, 1, 0, 0, 0, 0, 3'b000));
        end
        3: begin
          inst = r_type(5'd3, 5'd3, 5'd4, 5'd0, F_ADDU); mem_we = 1'b1; mem_is_load = 1'b1;
          wb_we = 1'b1; wb_index = 5'd3; wb_value = 32'd9;
          issue("fwd_wb_load", mk(5'd4, 32'd18, 1, 0, 0, 0, 0, 3'b000));
        end
        4: begin
          inst = r_type(5'd0, 5'd2, 5'd5, 5'd0, F_ADDU); rs_rf = 32'hDEAD; rt_rf = 32'd1;
          wb_we = 1'b1; wb_index = 5'd0; wb_value = 32'd100;
          issue("src_r0", mk(5'd5, 32'd1, 1, 0, 0, 0, 0, 3'b000));
        end
        5: begin
          inst = r_type(5'd1, 5'd2, 5'd3, 5'd0, F_ADDU); rs_rf = 32'd1; rt_rf = 32'd1; squash = 1'b1;
          issue("squash_r3", mk(5'd3, 32'd2, 1, 0, 0, 0, 1, 3'b000));
        end
        6: begin
          inst = r_type(5'd3, 5'd0, 5'd6, 5'd0, F_ADDU); rs_rf = 32'd40; rt_rf = 32'd77; mem_we = 1'b1;
          issue("no_fwd_killed", mk(5'd6, 32'd40, 1, 0, 0, 0, 0, 3'b000));
        end
        default: begin
          inst = r_type(5'd6, 5'd0, 5'd7, 5'd0, F_ADDU); mem_we = 1'b1;
          wb_we = 1'b1; wb_index = 5'd6; wb_value = 32'd5;
          issue("mem_over_wb", mk(5'd7, 32'd40, 1, 0, 0, 0, 0, 3'b000));
        end
      endcase
      x = sb.pop_front(); nm = nm_q.pop_front();
      compared++;
      if ({rd_index, rd_value & x.vmask, br_late_enable, memop_disable, alu_exception} !==
          {x.idx, x.val & x.vmask, x.br, x.md, x.exc}) begin
        mismatched++;
        $display("[TB] FAIL %s: got idx=%0d val=%h br=%b md=%b exc=%b, want idx=%0d val=%h br=%b md=%b exc=%b",
                 nm, rd_index, rd_value, br_late_enable, memop_disable, alu_exception,
                 x.idx, x.val, x.br, x.md, x.exc);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t x; string nm;
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      case (i)
        0: begin
          inst = r_type(5'd1, 5'd2, 5'd3, 5'd0, F_ADD); rs_rf = 32'h7FFF_FFFF; rt_rf = 32'd1;
          issue("add_ovf", mk(5'd3, 32'h8000_0000, 1, 0, 0, 0, 1, 3'b001));
        end
        1: begin
          inst = r_type(5'd1, 5'd2, 5'd3, 5'd0, F_ADDU); rs_rf = 32'h7FFF_FFFF; rt_rf = 32'd1;
          issue("addu_wrap", mk(5'd3, 32'h8000_0000, 1, 0, 0, 0, 0, 3'b000));
        end
        2: begin
          inst = r_type(5'd1, 5'd2, 5'd3, 5'd0, F_SUB); rs_rf = 32'h8000_0000; rt_rf = 32'd1;
          issue("sub_ovf", mk(5'd3, 32'h7FFF_FFFF, 1, 0, 0, 0, 1, 3'b001));
        end
        3: begin
          inst = i_type(OP_ADDI, 5'd1, 5'd2, 16'h0001); rs_rf = 32'h7FFF_FFFF;
          const_to_rt = 1'b1; imm_sext = 1'b1; dest_sel_rt = 1'b1;
          issue("addi_ovf", mk(5'd2, 32'h8000_0000, 1, 0, 0, 0, 1, 3'b001));
        end
        default: begin
          inst = r_type(5'd1, 5'd2, 5'd3, 5'd0, F_ADD); rs_rf = 32'h7FFF_FFFF; rt_rf = 32'd1;
          squash = 1'b1;
          issue("add_ovf_squash", mk(5'd3, 32'h8000_0000, 1, 0, 0, 0, 1, 3'b000));
        end
      endcase
      x = sb.pop_front(); nm = nm_q.pop_front();
      compared++;
      if ({rd_index, rd_value & x.vmask, br_late_enable, memop_disable, alu_exception} !==
          {x.idx, x.val & x.vmask, x.br, x.md, x.exc}) begin
        mismatched++;
        $display("[TB] FAIL %s: got idx=%0d val=%h br=%b md=%b exc=%b, want idx=%0d val=%h br=%b md=%b exc=%b",
                 nm, rd_index, rd_value, br_late_enable, memop_disable, alu_exception,
                 x.idx, x.val, x.br, x.md, x.exc);
      end
    end
  endtask

  task automatic test_branches();
    exp_t x; string nm;
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      pc = 32'h100; rs_rf = 32'd7; rt_rf = 32'd7;
      case (i)
        0: begin
          inst = i_type(OP_BEQ, 5'd1, 5'd2, 16'd4);
          issue("beq_taken", mk(5'd0, 0, 0, 1, 32'h114, 1, 0, 3'b000));
        end
        1: begin
          inst = i_type(OP_BEQ, 5'd1, 5'd2, 16'd4); squash = 1'b1;
          issue("beq_squash", mk(5'd0, 0, 0, 0, 0, 0, 1, 3'b000));
        end
        2: begin
          inst = i_type(OP_BNE, 5'd1, 5'd2, 16'd4);
          issue("bne_not_taken", mk(5'd0, 0, 0, 0, 0, 0, 0, 3'b000));
        end
        3: begin
          pc = 32'h200; rs_rf = 32'hFFFF_FFFF;
          inst = i_type(OP_REGIMM, 5'd1, RT_BLTZ, 16'hFFFE);
          issue("bltz_back", mk(5'd31, 0, 0, 1, 32'h1FC, 1, 0, 3'b000));
        end
        4: begin
          rs_rf = 32'd0; inst = i_type(OP_BGTZ, 5'd1, 5'd0, 16'd4);
          issue("bgtz_zero", mk(5'd0, 0, 0, 0, 0, 0, 0, 3'b000));
        end
        default: begin
          rs_rf = 32'd0; inst = i_type(OP_BLEZ, 5'd1, 5'd0, 16'd4);
          issue("blez_zero", mk(5'd0, 0, 0, 1, 32'h114, 1, 0, 3'b000));
        end
      endcase
      x = sb.pop_front(); nm = nm_q.pop_front();
      compared++;
      if ({rd_index, rd_value & x.vmask, br_late_enable, memop_disable, alu_exception} !==
          {x.idx, x.val & x.vmask, x.br, x.md, x.exc}) begin
        mismatched++;
        $display("[TB] FAIL %s: got idx=%0d val=%h br=%b md=%b exc=%b, want idx=%0d val=%h br=%b md=%b exc=%b",
                 nm, rd_index, rd_value, br_late_enable, memop_disable, alu_exception,
                 x.idx, x.val, x.br, x.md, x.exc);
      end
      if (x.chk_tgt) begin
        compared++;
        if (br_late_target !== x.tgt) begin
          mismatched++;
          $display("[TB] FAIL %s target: got %h, want %h", nm, br_late_target, x.tgt);
        end
      end
    end
  endtask

  task automatic test_jumps_and_reset();
    exp_t x; string nm;
    for (int i = 0; i < 7; i++) begin
      clear_inputs();
      case (i)
        0: begin
          inst = r_type(5'd5, 5'd0, 5'd31, 5'd0, F_JALR); pc = 32'h40; rs_rf = 32'h2000; dest_sel_ra = 1'b1;
          issue("jalr", mk(5'd31, 32'h48, 1, 1, 32'h2000, 1, 0, 3'b000));
        end
        1: begin
          inst = r_type(5'd6, 5'd0, 5'd0, 5'd0, F_JR); pc = 32'h80; rs_rf = 32'h3004;
          issue("jr", mk(5'd0, 0, 0, 1, 32'h3004, 1, 0, 3'b000));
        end
        2: begin
          inst = {OP_JAL, 26'h10}; pc = 32'h50; dest_sel_ra = 1'b1;
          issue("jal_no_late", mk(5'd31, 32'h58, 1, 0, 0, 0, 0, 3'b000));
        end
        3: begin
          inst = r_type(5'd0, 5'd0, 5'd0, 5'd0, F_SYSCALL);
          issue("syscall", mk(5'd0, 0, 0, 0, 0, 0, 1, 3'b100));
        end
        4: begin
          inst = r_type(5'd0, 5'd0, 5'd0, 5'd0, 6'h3F);
          issue("bad_funct", mk(5'd0, 0, 0, 0, 0, 0, 1, 3'b100));
        end
        5: begin
          inst = r_type(5'd6, 5'd0, 5'd0, 5'd0, F_JR); pc = 32'h80; rs_rf = 32'h3004; rst = 1'b1;
          issue("reset_midstream", mk(5'd0, 32'd0, 1, 0, RST_PC, 1, 0, 3'b000));
        end
        default: begin
          inst = r_type(5'd6, 5'd0, 5'd0, 5'd0, F_JR); rs_rf = 32'h44;
          issue("jr_after_reset", mk(5'd0, 0, 0, 1, 32'h44, 1, 0, 3'b000));
        end
      endcase
      x = sb.pop_front(); nm = nm_q.pop_front();
      compared++;
      if ({rd_index, rd_value & x.vmask, br_late_enable, memop_disable, alu_exception} !==
          {x.idx, x.val & x.vmask, x.br, x.md, x.exc}) begin
        mismatched++;
        $display("[TB] FAIL %s: got idx=%0d val=%h br=%b md=%b exc=%b, want idx=%0d val=%h br=%b md=%b exc=%b",
                 nm, rd_index, rd_value, br_late_enable, memop_disable, alu_exception,
                 x.idx, x.val, x.br, x.md, x.exc);
      end
      if (x.chk_tgt) begin
        compared++;
        if (br_late_target !== x.tgt) begin
          mismatched++;
          $display("[TB] FAIL %s target: got %h, want %h", nm, br_late_target, x.tgt);
        end
      end
    end
  endtask

  task automatic test_memory();
    exp_t x; string nm;
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      rs_rf = 32'h1000;
      case (i)
        0: begin
          inst = i_type(OP_LW, 5'd1, 5'd2, 16'h0002); dest_sel_rt = 1'b1;
          issue("lw_misalign", mk(5'd2, 32'h1002, 1, 0, 0, 0, 1, 3'b010));
        end
        1: begin
          inst = i_type(OP_LW, 5'd1, 5'd2, 16'h0004); dest_sel_rt = 1'b1;
          issue("lw_aligned", mk(5'd2, 32'h1004, 1, 0, 0, 0, 0, 3'b000));
        end
        2: begin
          inst = i_type(OP_SW, 5'd1, 5'd2, 16'hFFFC);
          issue("sw_neg_off", mk(5'd31, 32'h0FFC, 1, 0, 0, 0, 0, 3'b000));
        end
        default: begin
          inst = i_type(OP_SW, 5'd1, 5'd2, 16'hFFFF);
          issue("sw_misalign", mk(5'd31, 32'h0FFF, 1, 0, 0, 0, 1, 3'b010));
        end
      endcase
      x = sb.pop_front(); nm = nm_q.pop_front();
      compared++;
      if ({rd_index, rd_value & x.vmask, br_late_enable, memop_disable, alu_exception} !==
          {x.idx, x.val & x.vmask, x.br, x.md, x.exc}) begin
        mismatched++;
        $display("[TB] FAIL %s: got idx=%0d val=%h br=%b md=%b exc=%b, want idx=%0d val=%h br=%b md=%b exc=%b",
                 nm, rd_index, rd_value, br_late_enable, memop_disable, alu_exception,
                 x.idx, x.val, x.br, x.md, x.exc);
      end
    end
  endtask

  task automatic test_shifts_imm();
    exp_t x; string nm;
    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      case (i)
        0: begin
          inst = r_type(5'd0, 5'd2, 5'd3, 5'd4, F_SLL); rt_rf = 32'd1;
          issue("sll", mk(5'd3, 32'd16, 1, 0, 0, 0, 0, 3'b000));
        end
        1: begin
          inst = r_type(5'd0, 5'd2, 5'd3, 5'd4, F_SRA); rt_rf = 32'h8000_0000;
          issue("sra", mk(5'd3, 32'hF800_0000, 1, 0, 0, 0, 0, 3'b000));
        end
        2: begin
          inst = r_type(5'd0, 5'd2, 5'd3, 5'd4, F_SRL); rt_rf = 32'h8000_0000;
          issue("srl", mk(5'd3, 32'h0800_0000, 1, 0, 0, 0, 0, 3'b000));
        end
        3: begin
          inst = r_type(5'd1, 5'd2, 5'd3, 5'd0, F_SRLV); rs_rf = 32'h24; rt_rf = 32'h80;
          issue("srlv", mk(5'd3, 32'd8, 1, 0, 0, 0, 0, 3'b000));
        end
        4: begin
          inst = i_type(OP_LUI, 5'd0, 5'd2, 16'h1234); dest_sel_rt = 1'b1;
          issue("lui", mk(5'd2, 32'h1234_0000, 1, 0, 0, 0, 0, 3'b000));
        end
        5: begin
          inst = i_type(OP_SLTI, 5'd1, 5'd2, 16'hFFFF); rs_rf = 32'hFFFF_FFFB;
          const_to_rt = 1'b1; imm_sext = 1'b1; dest_sel_rt = 1'b1;
          issue("slti_true", mk(5'd2, 32'd1, 1, 0, 0, 0, 0, 3'b000));
        end
        6: begin
          inst = i_type(OP_SLTI, 5'd1, 5'd2, 16'hFFFF); rs_rf = 32'd7;
          const_to_rt = 1'b1; imm_sext = 1'b1; dest_sel_rt = 1'b1;
          issue("slti_false", mk(5'd2, 32'd0, 1, 0, 0, 0, 0, 3'b000));
        end
        7: begin
          inst = i_type(OP_SLTIU, 5'd1, 5'd2, 16'hFFFF); rs_rf = 32'd7;
          const_to_rt = 1'b1; imm_sext = 1'b1; dest_sel_rt = 1'b1;
          issue("sltiu", mk(5'd2, 32'd1, 1, 0, 0, 0, 0, 3'b000));
        end
        8: begin
          inst = i_type(OP_ORI, 5'd1, 5'd2, 16'hFFFF); rs_rf = 32'h0001_0000;
          const_to_rt = 1'b1; dest_sel_rt = 1'b1;
          issue("ori_zext", mk(5'd2, 32'h0001_FFFF, 1, 0, 0, 0, 0, 3'b000));
        end
        default: begin
          inst = r_type(5'd1, 5'd2, 5'd3, 5'd9, F_ADDU); rs_rf = 32'd1000; rt_rf = 32'd1;
          const_to_rs = 1'b1; imm_shamt = 1'b1; imm_sext = 1'b1;
          issue("shamt_const", mk(5'd3, 32'd10, 1, 0, 0, 0, 0, 3'b000));
        end
      endcase
      x = sb.pop_front(); nm = nm_q.pop_front();
      compared++;
      if ({rd_index, rd_value & x.vmask, br_late_enable, memop_disable, alu_exception} !==
          {x.idx, x.val & x.vmask, x.br, x.md, x.exc}) begin
        mismatched++;
        $display("[TB] FAIL %s: got idx=%0d val=%h br=%b md=%b exc=%b, want idx=%0d val=%h br=%b md=%b exc=%b",
                 nm, rd_index, rd_value, br_late_enable, memop_disable, alu_exception,
                 x.idx, x.val, x.br, x.md, x.exc);
      end
    end
  endtask

  task automatic test_random_ops();
    exp_t x; string nm;
    logic [5:0]  fn_tab [10];
    logic [31:0] a, b, r;
    logic [4:0]  rd;
    logic [5:0]  fn;
    fn_tab = '{F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU, F_SLLV, F_SRAV};
    for (int i = 0; i < 20; i++) begin
      clear_inputs();
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(31, 1));
      fn = fn_tab[i % 10];
      case (fn)
        F_ADDU:  r = a + b;
        F_SUBU:  r = a - b;
        F_AND:   r = a & b;
        F_OR:    r = a | b;
        F_XOR:   r = a ^ b;
        F_NOR:   r = ~(a | b);
        F_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        F_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
        F_SLLV:  r = b << a[4:0];
        default: r = $unsigned($signed(b) >>> a[4:0]);
      endcase
      inst = r_type(5'd1, 5'd2, rd, 5'd0, fn); rs_rf = a; rt_rf = b;
      issue($sformatf("rand_%0d_f%h", i, fn), mk(rd, r, 1, 0, 0, 0, 0, 3'b000));
      x = sb.pop_front(); nm = nm_q.pop_front();
      compared++;
      if ({rd_index, rd_value & x.vmask, br_late_enable, memop_disable, alu_exception} !==
          {x.idx, x.val & x.vmask, x.br, x.md, x.exc}) begin
        mismatched++;
        $display("[TB] FAIL %s: got idx=%0d val=%h br=%b md=%b exc=%b, want idx=%0d val=%h br=%b md=%b exc=%b",
                 nm, rd_index, rd_value, br_late_enable, memop_disable, alu_exception,
                 x.idx, x.val, x.br, x.md, x.exc);
      end
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_back_to_back();
    test_overflow();
    test_branches();
    test_jumps_and_reset();
    test_memory();
    test_shifts_imm();
    test_random_ops();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_bypass_stage.md
Name: alu_bypass_stage

Overview:
- Execute stage of the 5-stage MIPS-I integer pipeline: fetch, decode/regfetch, execute, mem, regwrite.
- Takes the decoded instruction, its PC and the register-file operands, and forwards newer results from the MEM and writeback stages.
- Performs the ALU operation, resolves register-based ("late") branches and flags exceptions.
- Registers the result for the MEM stage.

Parameters:
- RESET_PC, 32'h0, value of br_late_target after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset (see Behaviour)
- inst  in  32  instruction in execute
- pc  in  32  address of inst
- rs_rf  in  32  register-file value of inst[25:21]
- rt_rf  in  32  register-file value of inst[20:16]
- dest_sel_rt  in  1  destination = inst[20:16]
- dest_sel_ra  in  1  destination = 31; wins over dest_sel_rt
- imm_sext  in  1  immediate is sign-extended, else zero-extended
- imm_shamt  in  1  constant = {27'b0, inst[10:6]}; wins over imm_sext
- const_to_rs  in  1  replace operand A with the constant
- const_to_rt  in  1  replace operand B with the constant
- squash  in  1  inst is wrong-path
- mem_we  in  1  MEM-stage instruction writes a register
- mem_is_load  in  1  MEM-stage instruction is a load
- wb_we, wb_index, wb_value  in  1/5/32  register write happening this cycle
- rd_index  out  5  registered destination index
- rd_value  out  32  registered result or memory address
- br_late_enable  out  1  registered: redirect fetch
- br_late_target  out  32  registered redirect target
- memop_disable  out  1  registered: kill mem access and register write
- alu_exception  out  3  registered exception flags

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. While rst is high, every output clears to 0 except br_late_target, which takes RESET_PC.
- Forwarding is combinational. For each source index s (inst[25:21] for A, inst[20:16] for B), in priority order:
  - s==0 gives 0.
  - Else, if mem_we && !mem_is_load && rd_index==s && !memop_disable, use rd_value.
  - Else, if wb_we && wb_index==s, use wb_value.
  - Else use rs_rf / rt_rf.
  - Load-use distance of 1 is not covered; a load delay slot is mandated.
- Operands: const_to_rs / const_to_rt override the forwarded value. The constant is built from imm_shamt / imm_sext as described in Ports.
- Operation is selected from opcode/funct:
  - ADD, ADDU, SUB, SUBU; AND, OR, XOR, NOR; SLT, SLTU.
  - SLL, SRL, SRA, SLLV, SRLV, SRAV (shift amount = A[4:0] for the variable forms).
  - ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI; LUI = {imm, 16'b0}.
  - LW/SW: A + sext(imm).
  - JAL, JALR: pc+8.
  - All arithmetic is 32-bit wrap.
- Late branches; target is registered the cycle after execute:
  - BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ: taken gives target pc+4+(sext(imm)<<2).
  - JR, JALR: always taken, target A.
  - J and JAL are resolved in fetch, so br_late_enable stays 0 for them.
- Exceptions:
  - [0] signed overflow on ADD, ADDI, SUB.
  - [1] LW/SW address with bits [1:0] != 0.
  - [2] SYSCALL, BREAK, or unknown SPECIAL funct.
- memop_disable = squash | any exception bit.
- squash=1 forces: br_late_enable=0, alu_exception=0, memop_disable=1.
- Latency: exactly 1 cycle, no stall input; a new instruction is accepted every cycle.
- Destination index: default inst[15:11], then dest_sel_rt, then dest_sel_ra (highest priority).

Decomposition:
- Shared package mips_pkg: opcode/funct localparams, exception bit positions.
- Sub-module pipe_delay (WIDTH, DEPTH, RESET_VAL): synchronous-reset shift register. Used for the output registers and reused by the core for aligning control signals.

Test Plan:
- ADDU r3=r1+r2 with rs_rf=5, rt_rf=7 -> next cycle rd_index=3, rd_value=12, memop_disable=0, alu_exception=0.
- Back-to-back forwarding:
  - MEM-stage result rd_value=12, rd_index=3, mem_we=1, mem_is_load=0; next inst ADDU r4=r3+r3 with rs_rf=0 -> rd_value=24.
  - Same with mem_is_load=1, wb_we=1, wb_index=3, wb_value=9 -> rd_value=18.
- ADD 0x7FFFFFFF+1 -> alu_exception=3'b001, memop_disable=1, rd_value=0x80000000.
- BEQ at pc=0x100, imm=4, A==B -> br_late_enable=1, target=0x114. Same instruction with squash=1 -> br_late_enable=0, memop_disable=1.
- JALR r5 (A=0x2000) at pc=0x40 -> target=0x2000, rd_index=31, rd_value=0x48.
- Outputs cleared by rst mid-stream: assert rst during a taken JR -> next cycle all outputs 0, target=RESET_PC. LW with address 0x1002 -> alu_exception[1]=1.
